// File: rtl/unified_mem_arbiter_if.sv
// Request/memory bus bundle for unified_mem_arbiter: fetch port, data port and
// the shared single-port memory side. The arbiter connects through the slave modport.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store.
// Optional MEM_TIMEOUT_EN: abort an access after TIMEOUT unacknowledged cycles.
module unified_mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   unified_mem_arbiter_if.slave bus,
   output logic                 stall,
   output logic                 timeout_err
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_D = 2'd2} state_t;
   typedef enum logic {GRANT_IF = 1'b0, GRANT_D = 1'b1} grant_t;

   state_t            state_q, state_d;
   grant_t            last_q, last_d;
   logic              busy, done, abort;
   logic              if_ack_q, d_ack_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q, rd_value;

   assign busy     = (state_q != IDLE);
   assign done     = busy & (bus.mem_ack | abort);
   assign rd_value = abort ? DATA_W'(16'hDEAD) : bus.mem_rdata;

`ifdef MEM_TIMEOUT_EN
   localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

   logic [3:0] wait_q;
   logic       timeout_err_q;

   // a real ack on the final cycle still wins over the abort
   assign abort = busy & ~bus.mem_ack & (wait_q == TIMEOUT_CNT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_q        <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (!busy)
            wait_q <= '0;
         else if (!bus.mem_ack)
            wait_q <= wait_q + 4'd1;
         if (abort)
            timeout_err_q <= 1'b1;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign abort       = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= GRANT_D;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // last_grant only moves on collisions so the collision order alternates
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (bus.if_req && bus.d_req) begin
               if (last_q == GRANT_D) begin
                  state_d = BUSY_IF;
                  last_d  = GRANT_IF;
               end else begin
                  state_d = BUSY_D;
                  last_d  = GRANT_D;
               end
            end else if (bus.if_req) begin
               state_d = BUSY_IF;
            end else if (bus.d_req) begin
               state_d = BUSY_D;
            end
         end
         BUSY_IF, BUSY_D: begin
            if (done)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         if (state_q == IDLE) begin
            if (state_d == BUSY_IF) begin
               mem_addr_q <= bus.if_addr;
               mem_we_q   <= 1'b0;
            end else if (state_d == BUSY_D) begin
               mem_addr_q  <= bus.d_addr;
               mem_we_q    <= bus.d_we;
               mem_wdata_q <= bus.d_wdata;
            end
         end else if (done) begin
            mem_we_q <= 1'b0;
            if (state_q == BUSY_IF) begin
               if_ack_q   <= 1'b1;
               if_rdata_q <= rd_value;
            end else begin
               d_ack_q <= 1'b1;
               if (!mem_we_q)
                  d_rdata_q <= rd_value;
            end
         end
      end
   end

   assign bus.mem_req   = busy;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.d_rdata   = d_rdata_q;

   assign stall = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: vector table of single accesses plus
// hand sequences for reset abort, collisions, back-to-back fetch and timeout.
module tb_unified_mem_arbiter;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic stall, timeout_err;

   unified_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   unified_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .stall       (stall),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          wait_n;
      logic [15:0] mdata;
      int          exp_lat;
      int          exp_stall;
      int          exp_busy;
      logic        exp_we;
      logic [15:0] exp_rdata;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   int          mem_wait = 0;
   logic [15:0] mem_data = '0;
   bit          hang     = 1'b0;
   bit          idle_ack = 1'b0;
   logic [15:0] log_addr [64];
   int          log_n    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // memory model: acks after mem_wait cycles of mem_req, logs each completed address
   initial begin
      int cnt;
      cnt = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         bus.mem_ack = 1'b0;
         if (bus.mem_req && !hang) begin
            if (cnt >= mem_wait) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_data;
               cnt = 0;
               if (log_n < 64) begin
                  log_addr[log_n] = bus.mem_addr;
                  log_n++;
               end
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
            if (!bus.mem_req) begin
               bus.mem_ack   = idle_ack;
               bus.mem_rdata = mem_data;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_vec(input vec_t v, input string tag);
      int ack_at, stall_n, busy_n, hold_bad;
      ack_at = 0; stall_n = 0; busy_n = 0; hold_bad = 0;
      mem_wait = v.wait_n;
      mem_data = v.mdata;
      hang     = 1'b0;
      @(posedge clk); #1;
      if (v.is_d) begin
         bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = v.addr;
      end
      for (int i = 1; i <= 40 && ack_at == 0; i++) begin
         @(negedge clk);
         if (bus.mem_req) begin
            busy_n++;
            if (bus.mem_addr !== v.addr || bus.mem_we !== v.exp_we ||
                (v.exp_we && bus.mem_wdata !== v.wdata))
               hold_bad++;
         end
         if (v.is_d ? bus.d_ack : bus.if_ack)
            ack_at = i;
         else if (stall)
            stall_n++;
      end
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      check({tag, "_latency"}, ack_at, v.exp_lat);
      check({tag, "_stall"}, stall_n, v.exp_stall);
      check({tag, "_busy"}, busy_n, v.exp_busy);
      check({tag, "_hold"}, hold_bad, 0);
      @(negedge clk);
      check({tag, "_pulse"}, v.is_d ? bus.d_ack : bus.if_ack, 1'b0);
      check({tag, "_rdata"}, v.is_d ? bus.d_rdata : bus.if_rdata, v.exp_rdata);
   endtask

   task automatic collide(input logic [15:0] ia, input logic [15:0] da,
                          input bit if_first, input string tag);
      int base;
      bit if_done, d_done;
      base = log_n; if_done = 0; d_done = 0;
      mem_wait = 1; hang = 1'b0;
      @(posedge clk); #1;
      bus.if_req = 1'b1; bus.if_addr = ia;
      bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = da;
      for (int i = 0; i < 40 && !(if_done && d_done); i++) begin
         @(negedge clk);
         if (bus.if_ack) begin bus.if_req = 1'b0; if_done = 1; end
         if (bus.d_ack)  begin bus.d_req  = 1'b0; d_done  = 1; end
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      check({tag, "_done"}, {if_done, d_done}, 2'b11);
      check({tag, "_count"}, log_n - base, 2);
      check({tag, "_first"}, log_addr[base], if_first ? ia : da);
      check({tag, "_second"}, log_addr[base+1], if_first ? da : ia);
   endtask

   initial begin
      vec_t vecs[6];
      vec_t post_fetch;
      int   ack_at, acks, base;

      vecs[0] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 0, 16'h1234, 3, 2, 1, 1'b0, 16'h1234};
      vecs[1] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 3, 16'hEEEE, 6, 5, 4, 1'b1, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1, 16'h5A5A, 4, 3, 2, 1'b0, 16'h5A5A};
      vecs[3] = '{1'b1, 1'b1, 16'h0030, 16'h0001, 0, 16'h0000, 3, 2, 1, 1'b1, 16'h5A5A};
      vecs[4] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 2, 16'hFFFF, 5, 4, 3, 1'b0, 16'hFFFF};
      vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 0, 16'h0000, 3, 2, 1, 1'b0, 16'h0000};
      post_fetch = '{1'b0, 1'b0, 16'h0040, 16'h0000, 0, 16'h4321, 3, 2, 1, 1'b0, 16'h4321};

      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 16'h0000);
      check("rst_acks", {bus.if_ack, bus.d_ack}, 2'b00);
      check("rst_rdata", {bus.if_rdata, bus.d_rdata}, 32'h0);
      check("rst_stall", stall, 1'b0);
      check("rst_timeout_err", timeout_err, 1'b0);
      @(posedge clk); #1 rst = 1'b1;

      for (int k = 0; k < 6; k++)
         run_vec(vecs[k], $sformatf("vec%0d", k));

      // mem_ack while idle must not produce acks or touch rdata
      mem_data = 16'h7777;
      idle_ack = 1'b1;
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.if_ack || bus.d_ack || bus.mem_req) acks++;
      end
      idle_ack = 1'b0;
      check("idle_ack_ignored", acks, 0);
      check("idle_ack_rdata", {bus.if_rdata, bus.d_rdata}, {16'hFFFF, 16'h0000});

      // reset while a load is in flight
      hang = 1'b1;
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0060;
      repeat (3) @(negedge clk);
      check("rstmid_busy", bus.mem_req, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("rstmid_async_req", bus.mem_req, 1'b0);
      bus.d_req = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.d_ack) acks++;
      end
      check("rstmid_no_ack", acks, 0);
      check("rstmid_rdata", bus.d_rdata, 16'h0000);
      hang = 1'b0;
      run_vec(post_fetch, "post_rst_fetch");

      // collisions alternate, fetch first after reset
      collide(16'h0100, 16'h0200, 1'b1, "coll0");
      collide(16'h0300, 16'h0400, 1'b0, "coll1");
      collide(16'h0500, 16'h0600, 1'b1, "coll2");

      // back-to-back fetches with req held, address advanced on each ack
      base = log_n; acks = 0; mem_wait = 0; mem_data = 16'h0000;
      @(posedge clk); #1;
      bus.if_req = 1'b1; bus.if_addr = 16'h0000;
      for (int i = 0; i < 40 && acks < 3; i++) begin
         @(negedge clk);
         if (bus.if_ack) begin
            acks++;
            if (acks == 3) bus.if_req = 1'b0;
            else bus.if_addr = bus.if_addr + 16'h0002;
         end
      end
      bus.if_req = 1'b0;
      repeat (4) @(negedge clk);
      check("b2b_acks", acks, 3);
      check("b2b_accesses", log_n - base, 3);
      check("b2b_addr0", log_addr[base], 16'h0000);
      check("b2b_addr1", log_addr[base+1], 16'h0002);
      check("b2b_addr2", log_addr[base+2], 16'h0004);

      // load that memory never acknowledges
      hang = 1'b1; ack_at = 0;
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0070;
      for (int i = 1; i <= 30 && ack_at == 0; i++) begin
         @(negedge clk);
         if (bus.d_ack) begin
            ack_at = i;
            bus.d_req = 1'b0;
         end
      end
`ifdef MEM_TIMEOUT_EN
      check("to_latency", ack_at, TIMEOUT + 3);
      check("to_rdata", bus.d_rdata, 16'hDEAD);
      check("to_err_set", timeout_err, 1'b1);
      repeat (3) @(negedge clk);
      check("to_err_sticky", timeout_err, 1'b1);
      check("to_req_dropped", bus.mem_req, 1'b0);
      rst = 1'b0;
      #1;
      check("to_err_cleared", timeout_err, 1'b0);
`else
      check("to_no_ack", ack_at, 0);
      check("to_still_waiting", bus.mem_req, 1'b1);
      check("to_stall", stall, 1'b1);
      check("to_err_zero", timeout_err, 1'b0);
      rst = 1'b0;
      #1;
      check("to_rst_abort", bus.mem_req, 1'b0);
`endif
      bus.d_req = 1'b0;
      hang = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port 16-bit unified memory between the instruction-fetch path (PC side) and the load/store data path (ALU address / register write data side).
- Sits between the program counter / register-file datapath and the external memory.
- Sequences each access with a req/ack handshake and round-robin arbitration on collisions.
- Drives a stall output that the PC and register-file write enable use to freeze the single-cycle datapath while memory is busy.

Parameters:
- ADDR_W, 16, width of all address buses
- DATA_W, 16, width of all data buses
- TIMEOUT, 15, max cycles to wait for mem_ack (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset; rst=0 resets the block immediately
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address (PC), stable while if_req=1
- if_rdata  out  DATA_W  fetched instruction
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=store, 0=load; stable while d_req=1
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_ack  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completion, may be high in the first mem_req cycle
- stall  out  1  datapath freeze
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=DATA (so fetch wins the first collision).
- Reset is asynchronous. Asserting rst mid-transaction drops mem_req immediately; no ack is issued for the aborted access.
- States:
  - IDLE: grant on sampled requests.
    - Only if_req → BUSY_IF.
    - Only d_req → BUSY_D.
    - Both → grant the port that is not last_grant; update last_grant.
  - BUSY_IF / BUSY_D: mem_req=1. mem_addr/mem_we/mem_wdata are registered at grant and held constant (mem_we=0 for fetch).
  - On a cycle with mem_ack=1 → IDLE:
    - mem_req deasserts at that edge.
    - Load or fetch: mem_rdata is latched into if_rdata or d_rdata.
    - The matching ack pulses for exactly the next cycle.
- Latency: request sampled at edge N → mem_req high in cycle N+1 → ack in cycle N+1+W+1, where W = mem_ack wait cycles (minimum 2 cycles).
- Port contract: req sampled high in IDLE during that port's own ack cycle is a new transaction. The requester must update the address at the ack edge or drop req.
- Arbitration: the ack'd port does not block the other. A requester waiting during a grant is granted in the ack cycle if it is the only requester, or if round-robin selects it.
- Stores: d_ack pulses; d_rdata is unchanged.
- rdata registers hold their value until the next ack of the same port.
- mem_ack while IDLE is ignored.
- stall is combinational: (if_req & ~if_ack) | (d_req & ~d_ack).
- No writes to mem_* outside BUSY states; no X on outputs after reset.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter clears at grant and increments each BUSY cycle with mem_ack=0.
  - When the count reaches TIMEOUT: abort the access, drop mem_req, pulse the owning port's ack with rdata=16'hDEAD (stores: rdata unchanged), set timeout_err.
  - timeout_err stays set until reset.
- Not defined: the block waits indefinitely for mem_ack; timeout_err is tied 0 and no counter is built.

Test Plan:
- Reset mid-BUSY_D (rst=0 with mem_req=1) → mem_req=0 asynchronously, no d_ack, state IDLE after release; a following fetch completes normally.
- Fetch only, if_addr=16'h0004, memory acks in the first request cycle with 16'h1234 → mem_req one cycle, if_ack on cycle 2 after request, if_rdata=16'h1234, stall=1 for 2 cycles.
- Store d_addr=16'h0010, d_wdata=16'hBEEF, mem_ack after 3 wait cycles → mem_we=1, mem_wdata=16'hBEEF held 4 cycles, d_ack once, d_rdata unchanged.
- if_req and d_req rise in the same cycle after reset → fetch granted first, data next. A second collision grants data first; the grant order alternates on every collision.
- Back-to-back fetches with if_req held high and if_addr 0→2→4 on each ack edge → three mem accesses with addresses 0,2,4, no duplicate issue.
- With MEM_TIMEOUT_EN defined, load with mem_ack never asserted → d_ack after TIMEOUT+2 cycles, d_rdata=16'hDEAD, timeout_err=1 until reset. Without the macro: still waiting, timeout_err=0.
